ingress_rdreq_sched: RTL and testbench
======================================

INGRESS_RDREQ_SCHED -- requirements
Module: ingress_rdreq_sched

Interface
REQ-001 Parameters SHALL be: FIFO_DEPTH, default 4, read-request queue entries (power of two, 2..16); META_W, default 24, width of per-request completion metadata; TIMEOUT_CYC, default 255, register-read timeout in cycles.
REQ-002 Ports SHALL be:
  clk  input  1  system clock
  rst_n  input  1  synchronous active-low reset
  rd_req  input  1  one-cycle read-request strobe from read-request parser
  rd_tdest  input  10  {register[3], action[2], channel[4]} in bits [8:0]; bit 9 reserved, carried unchanged
  rd_meta  input  META_W  requester ID/tag for the completion, sampled with rd_req
  reg_rd_en  output  1  one-cycle register-read strobe to action modules
  reg_rd_tdest  output  10  destination of the current read
  reg_rd_data  input  32  read data from action modules
  reg_rd_vld  input  1  one-cycle read-data valid
  cpl_valid  output  1  completion valid
  cpl_data  output  32  completion payload
  cpl_meta  output  META_W  metadata of the request being completed
  cpl_err  output  1  completion is a timeout response
  cpl_rdy  input  1  completion sink ready
  ovf_err  output  1  one-cycle pulse: request dropped, queue full
  busy  output  1  queue non-empty or FSM not IDLE

Function
REQ-003 Each rd_req SHALL push {rd_tdest, rd_meta} into a FIFO_DEPTH-entry FIFO in the same cycle; push while full SHALL drop the request and pulse ovf_err the next cycle.
REQ-004 Push and pop in the same cycle SHALL be legal when full; the push SHALL then succeed with no ovf_err.
REQ-005 The FSM SHALL have states IDLE, ISSUE, WAIT, CPL.
REQ-006 IDLE -> ISSUE when the FIFO is non-empty; the head is popped into a holding register on that transition.
REQ-007 In ISSUE, reg_rd_en SHALL be 1 for exactly one cycle with reg_rd_tdest equal to the held tdest; next state WAIT.
REQ-008 In WAIT, reg_rd_vld SHALL capture reg_rd_data into cpl_data, clear cpl_err, and go to CPL; reg_rd_vld in any other state SHALL be ignored.
REQ-009 In CPL, cpl_valid SHALL be 1 with stable cpl_data/cpl_meta/cpl_err until cpl_valid && cpl_rdy; then go to IDLE, or directly to ISSUE (popping the next head) if the FIFO is non-empty.
REQ-010 Minimum latency SHALL be: rd_req at cycle N -> reg_rd_en at N+2 (FIFO write N, pop N+1, issue N+2); reg_rd_vld at M -> cpl_valid at M+1.
REQ-011 Only one read SHALL be outstanding; reg_rd_en SHALL never assert outside ISSUE.
REQ-012 reg_rd_tdest SHALL hold its last value when not issuing.
REQ-013 busy SHALL be 1 whenever the FIFO count is non-zero or the state is not IDLE.
REQ-014 The FIFO count SHALL be clog2(FIFO_DEPTH)+1 bits wide; pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-015 While rst_n=0 at a clk edge: state IDLE, FIFO empty, pointers 0, reg_rd_en 0, reg_rd_tdest 0, cpl_valid 0, cpl_data 0, cpl_meta 0, cpl_err 0, ovf_err 0, busy 0, timeout counter 0.
REQ-016 Reset mid-transaction SHALL discard queued and in-flight requests without emitting a completion; reg_rd_vld arriving after reset SHALL be ignored.

Configuration
REQ-017 With macro RDREQ_TIMEOUT_EN defined, a counter SHALL clear on ISSUE and increment each WAIT cycle; reaching TIMEOUT_CYC without reg_rd_vld SHALL go to CPL with cpl_data 32'hFFFF_FFFF and cpl_err 1. A reg_rd_vld arriving in that same cycle SHALL take priority over the timeout.
REQ-018 Without RDREQ_TIMEOUT_EN, no counter SHALL exist, WAIT SHALL wait indefinitely, and cpl_err SHALL be tied to 0.

Verification
REQ-019 Single read: rd_req with tdest 10'h0A3 and meta 24'h00_1234 at cycle 0; reg_rd_data 32'hCAFE_0001 returned 3 cycles after reg_rd_en -> reg_rd_en at cycle 2 with tdest 10'h0A3; cpl_valid with data CAFE_0001, meta 001234, cpl_err 0.
REQ-020 Burst overflow: 6 back-to-back rd_req with FIFO_DEPTH 4 while reg_rd_vld is withheld -> 5 requests accepted (4 queued plus 1 popped into the holding register), 1 ovf_err pulse, completions in arrival order.
REQ-021 Backpressure: cpl_rdy held 0 for 10 cycles -> cpl_* stable throughout; no further reg_rd_en until the handshake; the next ISSUE occurs the cycle after the handshake.
REQ-022 Timeout (RDREQ_TIMEOUT_EN, TIMEOUT_CYC=8): no reg_rd_vld -> cpl_valid 8 cycles after reg_rd_en with data FFFF_FFFF and cpl_err 1; a late reg_rd_vld is ignored.
REQ-023 Reset mid-WAIT with 2 requests queued -> no cpl_valid, busy 0 the cycle after reset; a new rd_req then completes normally.
REQ-024 Simultaneous push and pop while full -> no ovf_err, count unchanged, order preserved.

Source files
------------

// File: rtl/ingress_rdreq_sched_if.sv
// Read-request scheduler bus bundle: parser strobe, register-read port to the
// action modules, completion stream and status.
// slave  : scheduler side
// master : environment side (parser, action modules, completion sink)
interface ingress_rdreq_sched_if #(
  parameter int META_W = 24
);
  logic              rd_req;
  logic [9:0]        rd_tdest;
  logic [META_W-1:0] rd_meta;
  logic              reg_rd_en;
  logic [9:0]        reg_rd_tdest;
  logic [31:0]       reg_rd_data;
  logic              reg_rd_vld;
  logic              cpl_valid;
  logic [31:0]       cpl_data;
  logic [META_W-1:0] cpl_meta;
  logic              cpl_err;
  logic              cpl_rdy;
  logic              ovf_err;
  logic              busy;

  modport slave (
    input  rd_req, rd_tdest, rd_meta, reg_rd_data, reg_rd_vld, cpl_rdy,
    output reg_rd_en, reg_rd_tdest, cpl_valid, cpl_data, cpl_meta, cpl_err,
           ovf_err, busy
  );

  modport master (
    output rd_req, rd_tdest, rd_meta, reg_rd_data, reg_rd_vld, cpl_rdy,
    input  reg_rd_en, reg_rd_tdest, cpl_valid, cpl_data, cpl_meta, cpl_err,
           ovf_err, busy
  );
endinterface

// File: rtl/ingress_rdreq_sched.sv
// Ingress read-request scheduler: queues parsed read requests, issues them one
// at a time to the action-module register bus and returns completions in
// arrival order.
// Optional macro RDREQ_TIMEOUT_EN: adds a WAIT timeout that completes with
// data 32'hFFFF_FFFF and cpl_err=1 after TIMEOUT_CYC cycles.
//
// state | meaning
// IDLE  | nothing in flight, waiting for a queued request
// ISSUE | one-cycle reg_rd_en strobe for the held request
// WAIT  | waiting for reg_rd_vld (or timeout when enabled)
// CPL   | completion presented until cpl_rdy
module ingress_rdreq_sched #(
  parameter int FIFO_DEPTH  = 4,
  parameter int META_W      = 24,
  parameter int TIMEOUT_CYC = 255
) (
  input logic                  clk,
  input logic                  rst_n,
  ingress_rdreq_sched_if.slave rdq
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = 10 + META_W;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CPL} state_t;

  state_t            state_q, state_d;
  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              empty, full, push, pop;
  logic              cap_rd, cap_tmo, tmo_hit;
  logic              ovf_q;
  logic [9:0]        tdest_q;
  logic [META_W-1:0] meta_q;
  logic [31:0]       data_q;
  logic [ENT_W-1:0]  head;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign head  = mem_q[rd_ptr_q];
  // A pop in the same cycle frees a slot, so a push against a full queue
  // still succeeds then.
  assign push  = rdq.rd_req && (!full || pop);

  // Queue storage, not reset: validity is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {rdq.rd_tdest, rdq.rd_meta};
  end

  // Queue pointers, occupancy and overflow pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      ovf_q <= rdq.rd_req && full && !pop;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and pop/capture strobes; read data wins over timeout.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    cap_rd  = 1'b0;
    cap_tmo = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (rdq.reg_rd_vld) begin
          cap_rd  = 1'b1;
          state_d = S_CPL;
        end else if (tmo_hit) begin
          cap_tmo = 1'b1;
          state_d = S_CPL;
        end
      end
      S_CPL: begin
        if (rdq.cpl_rdy) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Holding register for the request in flight and its completion data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tdest_q <= '0;
      meta_q  <= '0;
      data_q  <= '0;
    end else begin
      if (pop) begin
        tdest_q <= head[ENT_W-1 -: 10];
        meta_q  <= head[META_W-1:0];
      end
      if (cap_rd)       data_q <= rdq.reg_rd_data;
      else if (cap_tmo) data_q <= 32'hFFFF_FFFF;
    end
  end

`ifdef RDREQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_q;
  logic             err_q;

  // The counter includes the ISSUE cycle, so it reaches TIMEOUT_CYC on the
  // edge that moves WAIT to CPL, TIMEOUT_CYC cycles after the strobe.
  assign tmo_hit = (state_q == S_WAIT) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  // Timeout counter: cleared when a request is popped, counts ISSUE and WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else if (pop) begin
      tmo_q <= '0;
    end else if (state_q == S_ISSUE || state_q == S_WAIT) begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end

  // Error flag follows whichever event closed the WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n)       err_q <= 1'b0;
    else if (cap_rd)  err_q <= 1'b0;
    else if (cap_tmo) err_q <= 1'b1;
  end

  assign rdq.cpl_err = err_q;
`else
  assign tmo_hit     = 1'b0;
  assign rdq.cpl_err = 1'b0;
`endif

  assign rdq.reg_rd_en    = (state_q == S_ISSUE);
  assign rdq.reg_rd_tdest = tdest_q;
  assign rdq.cpl_valid    = (state_q == S_CPL);
  assign rdq.cpl_data     = data_q;
  assign rdq.cpl_meta     = meta_q;
  assign rdq.ovf_err      = ovf_q;
  assign rdq.busy         = !empty || (state_q != S_IDLE);
endmodule

// File: tb/tb_ingress_rdreq_sched.sv
// Directed bench for ingress_rdreq_sched. Inputs change and outputs are
// sampled on the falling edge; "cycle k" is the period ending at posedge k.
module tb_ingress_rdreq_sched;
  localparam int META_W = 24;
`ifdef RDREQ_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  ingress_rdreq_sched_if #(.META_W(META_W)) rdq ();

  ingress_rdreq_sched #(
    .FIFO_DEPTH (4),
    .META_W     (META_W),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rdq  (rdq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++; if (rdq.reg_rd_en !== 1'b0) begin n_bad++; $display("FAIL rst_en: got %b want 0", rdq.reg_rd_en); end
    n_cmp++; if (rdq.reg_rd_tdest !== 10'h0) begin n_bad++; $display("FAIL rst_tdest: got %h want 000", rdq.reg_rd_tdest); end
    n_cmp++; if (rdq.cpl_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", rdq.cpl_valid); end
    n_cmp++; if (rdq.cpl_data !== 32'h0) begin n_bad++; $display("FAIL rst_data: got %h want 0", rdq.cpl_data); end
    n_cmp++; if (rdq.cpl_meta !== 24'h0) begin n_bad++; $display("FAIL rst_meta: got %h want 0", rdq.cpl_meta); end
    n_cmp++; if (rdq.cpl_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", rdq.cpl_err); end
    n_cmp++; if (rdq.ovf_err !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b want 0", rdq.ovf_err); end
    n_cmp++; if (rdq.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", rdq.busy); end
    rst_n = 1'b1;
    tick();
    // read data while idle must be ignored
    rdq.reg_rd_vld = 1'b1; rdq.reg_rd_data = 32'h1111_2222;
    tick();
    rdq.reg_rd_vld = 1'b0;
    n_cmp++; if ({rdq.cpl_valid, rdq.busy, rdq.cpl_data} !== {1'b0, 1'b0, 32'h0})
      begin n_bad++; $display("FAIL idle_vld_ignored: got v=%b busy=%b d=%h want v=0 busy=0 d=0", rdq.cpl_valid, rdq.busy, rdq.cpl_data); end
  endtask

  task automatic test_single_read();
    rdq.rd_req = 1'b1; rdq.rd_tdest = 10'h0A3; rdq.rd_meta = 24'h00_1234;
    tick();  // cycle 1
    rdq.rd_req = 1'b0;
    n_cmp++; if ({rdq.reg_rd_en, rdq.busy} !== 2'b01) begin n_bad++; $display("FAIL sr_c1: got en=%b busy=%b want en=0 busy=1", rdq.reg_rd_en, rdq.busy); end
    tick();  // cycle 2
    n_cmp++; if (rdq.reg_rd_en !== 1'b1) begin n_bad++; $display("FAIL sr_en_c2: got %b want 1", rdq.reg_rd_en); end
    n_cmp++; if (rdq.reg_rd_tdest !== 10'h0A3) begin n_bad++; $display("FAIL sr_tdest: got %h want 0a3", rdq.reg_rd_tdest); end
    tick();  // cycle 3
    n_cmp++; if (rdq.reg_rd_en !== 1'b0) begin n_bad++; $display("FAIL sr_en_c3: got %b want 0", rdq.reg_rd_en); end
    tick(); tick();  // cycle 5
    n_cmp++; if (rdq.cpl_valid !== 1'b0) begin n_bad++; $display("FAIL sr_early_valid: got %b want 0", rdq.cpl_valid); end
    rdq.reg_rd_vld = 1'b1; rdq.reg_rd_data = 32'hCAFE_0001;
    tick();  // cycle 6
    rdq.reg_rd_vld = 1'b0;
    n_cmp++; if (rdq.cpl_valid !== 1'b1) begin n_bad++; $display("FAIL sr_valid: got %b want 1", rdq.cpl_valid); end
    n_cmp++; if (rdq.cpl_data !== 32'hCAFE_0001) begin n_bad++; $display("FAIL sr_data: got %h want cafe0001", rdq.cpl_data); end
    n_cmp++; if (rdq.cpl_meta !== 24'h00_1234) begin n_bad++; $display("FAIL sr_meta: got %h want 001234", rdq.cpl_meta); end
    n_cmp++; if (rdq.cpl_err !== 1'b0) begin n_bad++; $display("FAIL sr_err: got %b want 0", rdq.cpl_err); end
    rdq.cpl_rdy = 1'b1;
    tick();
    rdq.cpl_rdy = 1'b0;
    n_cmp++; if ({rdq.cpl_valid, rdq.busy, rdq.reg_rd_tdest} !== {1'b0, 1'b0, 10'h0A3})
      begin n_bad++; $display("FAIL sr_after: got v=%b busy=%b tdest=%h want v=0 busy=0 tdest=0a3", rdq.cpl_valid, rdq.busy, rdq.reg_rd_tdest); end
  endtask

`ifdef RDREQ_TIMEOUT_EN
  task automatic test_timeout();
    rdq.rd_req = 1'b1; rdq.rd_tdest = 10'h333; rdq.rd_meta = 24'h0E_0001;
    tick();
    rdq.rd_req = 1'b0;
    tick();  // strobe cycle T
    n_cmp++; if (rdq.reg_rd_en !== 1'b1) begin n_bad++; $display("FAIL to_en: got %b want 1", rdq.reg_rd_en); end
    for (int i = 1; i < 8; i++) begin
      tick();
      n_cmp++; if (rdq.cpl_valid !== 1'b0) begin n_bad++; $display("FAIL to_early_%0d: got %b want 0", i, rdq.cpl_valid); end
    end
    tick();  // T+8
    n_cmp++; if ({rdq.cpl_valid, rdq.cpl_err, rdq.cpl_data, rdq.cpl_meta} !== {1'b1, 1'b1, 32'hFFFF_FFFF, 24'h0E_0001})
      begin n_bad++; $display("FAIL to_cpl: got v=%b e=%b d=%h m=%h want v=1 e=1 d=ffffffff m=0e0001", rdq.cpl_valid, rdq.cpl_err, rdq.cpl_data, rdq.cpl_meta); end
    rdq.reg_rd_vld = 1'b1; rdq.reg_rd_data = 32'h1234_5678;
    tick();
    rdq.reg_rd_vld = 1'b0;
    n_cmp++; if ({rdq.cpl_valid, rdq.cpl_err, rdq.cpl_data} !== {1'b1, 1'b1, 32'hFFFF_FFFF})
      begin n_bad++; $display("FAIL to_late_vld: got v=%b e=%b d=%h want v=1 e=1 d=ffffffff", rdq.cpl_valid, rdq.cpl_err, rdq.cpl_data); end
    rdq.cpl_rdy = 1'b1;
    tick();
    rdq.cpl_rdy = 1'b0;
    n_cmp++; if (rdq.busy !== 1'b0) begin n_bad++; $display("FAIL to_busy: got %b want 0", rdq.busy); end
  endtask
`endif

  task automatic test_overflow();
    int ovf_seen = 0;
    for (int i = 0; i < 6; i++) begin
      rdq.rd_req = 1'b1; rdq.rd_tdest = 10'h100 + 10'(i); rdq.rd_meta = 24'h00_A000 + 24'(i);
      tick();  // cycle i+1
      rdq.rd_req = 1'b0;
      if (rdq.ovf_err === 1'b1) ovf_seen++;
      if (i == 1) begin
        n_cmp++; if ({rdq.reg_rd_en, rdq.reg_rd_tdest} !== {1'b1, 10'h100})
          begin n_bad++; $display("FAIL ov_issue0: got en=%b tdest=%h want en=1 tdest=100", rdq.reg_rd_en, rdq.reg_rd_tdest); end
      end
      if (i == 5) begin
        n_cmp++; if (rdq.ovf_err !== 1'b1) begin n_bad++; $display("FAIL ov_pulse: got %b want 1", rdq.ovf_err); end
      end
    end
    tick();  // cycle 7
    n_cmp++; if (rdq.ovf_err !== 1'b0) begin n_bad++; $display("FAIL ov_pulse_end: got %b want 0", rdq.ovf_err); end
    n_cmp++; if (ovf_seen != 1) begin n_bad++; $display("FAIL ov_count: got %0d want 1", ovf_seen); end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        n_cmp++; if ({rdq.reg_rd_en, rdq.reg_rd_tdest} !== {1'b1, 10'h100 + 10'(k)})
          begin n_bad++; $display("FAIL ov_issue%0d: got en=%b tdest=%h want en=1 tdest=%h", k, rdq.reg_rd_en, rdq.reg_rd_tdest, 10'h100 + 10'(k)); end
      end
      tick();
      rdq.reg_rd_vld = 1'b1; rdq.reg_rd_data = 32'hD000_0000 + 32'(k);
      tick();
      rdq.reg_rd_vld = 1'b0;
      n_cmp++; if ({rdq.cpl_valid, rdq.cpl_meta, rdq.cpl_data} !== {1'b1, 24'h00_A000 + 24'(k), 32'hD000_0000 + 32'(k)})
        begin n_bad++; $display("FAIL ov_cpl%0d: got v=%b m=%h d=%h want v=1 m=%h d=%h", k, rdq.cpl_valid, rdq.cpl_meta, rdq.cpl_data, 24'h00_A000 + 24'(k), 32'hD000_0000 + 32'(k)); end
      rdq.cpl_rdy = 1'b1;
      tick();
      rdq.cpl_rdy = 1'b0;
    end
    n_cmp++; if ({rdq.busy, rdq.reg_rd_en, rdq.cpl_valid} !== 3'b000)
      begin n_bad++; $display("FAIL ov_drained: got busy=%b en=%b v=%b want 0 0 0", rdq.busy, rdq.reg_rd_en, rdq.cpl_valid); end
  endtask

  task automatic test_backpressure();
    rdq.rd_req = 1'b1; rdq.rd_tdest = 10'h055; rdq.rd_meta = 24'h0B_0001;
    tick();
    rdq.rd_req = 1'b0;
    tick();
    n_cmp++; if (rdq.reg_rd_en !== 1'b1) begin n_bad++; $display("FAIL bp_issue: got %b want 1", rdq.reg_rd_en); end
    tick();
    rdq.reg_rd_vld = 1'b1; rdq.reg_rd_data = 32'h5A5A_0001;
    tick();
    rdq.reg_rd_vld = 1'b0;
    rdq.rd_req = 1'b1; rdq.rd_tdest = 10'h0AA; rdq.rd_meta = 24'h0B_0002;
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if ({rdq.cpl_valid, rdq.cpl_data, rdq.cpl_meta, rdq.cpl_err, rdq.reg_rd_en} !== {1'b1, 32'h5A5A_0001, 24'h0B_0001, 1'b0, 1'b0})
        begin n_bad++; $display("FAIL bp_hold%0d: got v=%b d=%h m=%h e=%b en=%b want v=1 d=5a5a0001 m=0b0001 e=0 en=0", i, rdq.cpl_valid, rdq.cpl_data, rdq.cpl_meta, rdq.cpl_err, rdq.reg_rd_en); end
      tick();
      rdq.rd_req = 1'b0;
    end
    rdq.cpl_rdy = 1'b1;
    tick();
    rdq.cpl_rdy = 1'b0;
    n_cmp++; if ({rdq.reg_rd_en, rdq.reg_rd_tdest, rdq.cpl_valid} !== {1'b1, 10'h0AA, 1'b0})
      begin n_bad++; $display("FAIL bp_next_issue: got en=%b tdest=%h v=%b want en=1 tdest=0aa v=0", rdq.reg_rd_en, rdq.reg_rd_tdest, rdq.cpl_valid); end
    tick();
    rdq.reg_rd_vld = 1'b1; rdq.reg_rd_data = 32'h5A5A_0002;
    tick();
    rdq.reg_rd_vld = 1'b0;
    n_cmp++; if ({rdq.cpl_valid, rdq.cpl_meta, rdq.cpl_data} !== {1'b1, 24'h0B_0002, 32'h5A5A_0002})
      begin n_bad++; $display("FAIL bp_cpl2: got v=%b m=%h d=%h want v=1 m=0b0002 d=5a5a0002", rdq.cpl_valid, rdq.cpl_meta, rdq.cpl_data); end
    rdq.cpl_rdy = 1'b1;
    tick();
    rdq.cpl_rdy = 1'b0;
    n_cmp++; if (rdq.busy !== 1'b0) begin n_bad++; $display("FAIL bp_busy: got %b want 0", rdq.busy); end
  endtask

  task automatic test_full_pushpop();
    logic [23:0] em [5];
    logic [9:0]  et [5];
    em[0] = 24'h0D_0001; em[1] = 24'h0D_0002; em[2] = 24'h0D_0003; em[3] = 24'h0D_0004; em[4] = 24'h0D_0020;
    et[0] = 10'h181;     et[1] = 10'h182;     et[2] = 10'h183;     et[3] = 10'h184;     et[4] = 10'h1F0;
    for (int i = 0; i < 5; i++) begin
      rdq.rd_req = 1'b1; rdq.rd_tdest = 10'h180 + 10'(i); rdq.rd_meta = 24'h0D_0000 + 24'(i);
      tick();
      rdq.rd_req = 1'b0;
      n_cmp++; if (rdq.ovf_err !== 1'b0) begin n_bad++; $display("FAIL fp_fill_ovf%0d: got %b want 0", i, rdq.ovf_err); end
    end
    rdq.reg_rd_vld = 1'b1; rdq.reg_rd_data = 32'hF000_0000;
    tick();
    rdq.reg_rd_vld = 1'b0;
    n_cmp++; if ({rdq.cpl_valid, rdq.cpl_meta} !== {1'b1, 24'h0D_0000})
      begin n_bad++; $display("FAIL fp_cpl0: got v=%b m=%h want v=1 m=0d0000", rdq.cpl_valid, rdq.cpl_meta); end
    // push and pop together with the queue full
    rdq.rd_req = 1'b1; rdq.rd_tdest = 10'h1F0; rdq.rd_meta = 24'h0D_0020;
    rdq.cpl_rdy = 1'b1;
    tick();
    rdq.rd_req = 1'b0; rdq.cpl_rdy = 1'b0;
    n_cmp++; if ({rdq.ovf_err, rdq.reg_rd_en, rdq.reg_rd_tdest} !== {1'b0, 1'b1, 10'h181})
      begin n_bad++; $display("FAIL fp_pushpop: got ovf=%b en=%b tdest=%h want ovf=0 en=1 tdest=181", rdq.ovf_err, rdq.reg_rd_en, rdq.reg_rd_tdest); end
    // queue must still be full: a push without a pop is dropped
    rdq.rd_req = 1'b1; rdq.rd_tdest = 10'h1F1; rdq.rd_meta = 24'h0D_0030;
    tick();
    rdq.rd_req = 1'b0;
    n_cmp++; if (rdq.ovf_err !== 1'b1) begin n_bad++; $display("FAIL fp_still_full: got %b want 1", rdq.ovf_err); end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        n_cmp++; if ({rdq.reg_rd_en, rdq.reg_rd_tdest} !== {1'b1, et[k]})
          begin n_bad++; $display("FAIL fp_issue%0d: got en=%b tdest=%h want en=1 tdest=%h", k, rdq.reg_rd_en, rdq.reg_rd_tdest, et[k]); end
      end
      tick();
      rdq.reg_rd_vld = 1'b1; rdq.reg_rd_data = 32'hF000_0010 + 32'(k);
      tick();
      rdq.reg_rd_vld = 1'b0;
      n_cmp++; if ({rdq.cpl_valid, rdq.cpl_meta, rdq.cpl_data} !== {1'b1, em[k], 32'hF000_0010 + 32'(k)})
        begin n_bad++; $display("FAIL fp_cpl_order%0d: got v=%b m=%h d=%h want v=1 m=%h d=%h", k, rdq.cpl_valid, rdq.cpl_meta, rdq.cpl_data, em[k], 32'hF000_0010 + 32'(k)); end
      rdq.cpl_rdy = 1'b1;
      tick();
      rdq.cpl_rdy = 1'b0;
    end
    n_cmp++; if (rdq.busy !== 1'b0) begin n_bad++; $display("FAIL fp_drained: got %b want 0", rdq.busy); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      rdq.rd_req = 1'b1; rdq.rd_tdest = 10'h140 + 10'(i); rdq.rd_meta = 24'h0C_0000 + 24'(i);
      tick();
      rdq.rd_req = 1'b0;
    end
    n_cmp++; if (rdq.busy !== 1'b1) begin n_bad++; $display("FAIL rm_busy_pre: got %b want 1", rdq.busy); end
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++; if ({rdq.busy, rdq.cpl_valid, rdq.reg_rd_en, rdq.reg_rd_tdest, rdq.cpl_data} !== {1'b0, 1'b0, 1'b0, 10'h0, 32'h0})
      begin n_bad++; $display("FAIL rm_after_rst: got busy=%b v=%b en=%b tdest=%h d=%h want all 0", rdq.busy, rdq.cpl_valid, rdq.reg_rd_en, rdq.reg_rd_tdest, rdq.cpl_data); end
    rdq.reg_rd_vld = 1'b1; rdq.reg_rd_data = 32'hBAD0_BAD0;
    tick();
    rdq.reg_rd_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({rdq.cpl_valid, rdq.reg_rd_en, rdq.busy} !== 3'b000)
        begin n_bad++; $display("FAIL rm_quiet%0d: got v=%b en=%b busy=%b want 0 0 0", i, rdq.cpl_valid, rdq.reg_rd_en, rdq.busy); end
      tick();
    end
    rdq.rd_req = 1'b1; rdq.rd_tdest = 10'h2C5; rdq.rd_meta = 24'hAB_CDEF;
    tick();
    rdq.rd_req = 1'b0;
    tick();
    n_cmp++; if ({rdq.reg_rd_en, rdq.reg_rd_tdest} !== {1'b1, 10'h2C5})
      begin n_bad++; $display("FAIL rm_new_issue: got en=%b tdest=%h want en=1 tdest=2c5", rdq.reg_rd_en, rdq.reg_rd_tdest); end
    tick();
    rdq.reg_rd_vld = 1'b1; rdq.reg_rd_data = 32'h600D_0001;
    tick();
    rdq.reg_rd_vld = 1'b0;
    n_cmp++; if ({rdq.cpl_valid, rdq.cpl_meta, rdq.cpl_data, rdq.cpl_err} !== {1'b1, 24'hAB_CDEF, 32'h600D_0001, 1'b0})
      begin n_bad++; $display("FAIL rm_new_cpl: got v=%b m=%h d=%h e=%b want v=1 m=abcdef d=600d0001 e=0", rdq.cpl_valid, rdq.cpl_meta, rdq.cpl_data, rdq.cpl_err); end
    rdq.cpl_rdy = 1'b1;
    tick();
    rdq.cpl_rdy = 1'b0;
    n_cmp++; if (rdq.busy !== 1'b0) begin n_bad++; $display("FAIL rm_busy_end: got %b want 0", rdq.busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rdq.rd_req      = 1'b0;
    rdq.rd_tdest    = '0;
    rdq.rd_meta     = '0;
    rdq.reg_rd_data = '0;
    rdq.reg_rd_vld  = 1'b0;
    rdq.cpl_rdy     = 1'b0;
    test_reset();
    test_single_read();
`ifdef RDREQ_TIMEOUT_EN
    test_timeout();
`endif
    test_overflow();
    test_backpressure();
    test_full_pushpop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
